hazard_ctrl: RTL and testbench

Parametrised successor to the pipeline hazard unit of the 5-stage RV32I core. It detects load-use hazards with configurable load latency and kills wrong-path instructions on taken branch/JAL/JALR. It also stalls the pipe around multi-cycle EX operations (MUL/DIV) with a watchdog, and honours data-memory wait states. It sits beside the pipeline registers and drives their enable and flush controls.

---
 rtl/hazard_pkg.sv | 23 ++
 rtl/hazard_mc_fsm.sv | 77 +++++++
 rtl/hazard_ctrl.sv | 137 +++++++++++++
 tb/tb_hazard_ctrl.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller.
// PC-select encoding, controller FSM states, default register-index width.
package hazard_pkg;

    localparam int DEF_REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        PC_SEQ = 2'd0,
        PC_BR  = 2'd1,
        PC_JMP = 2'd2
    } pc_sel_e;

    typedef enum logic {
        RUN     = 1'b0,
        MC_BUSY = 1'b1
    } hz_state_e;

    // Taken branch or jump in EX; value 3 is treated as sequential.
    function automatic logic is_redirect(input logic [1:0] sel);
        return (sel == PC_BR) || (sel == PC_JMP);
    endfunction

endpackage

// File: rtl/hazard_mc_fsm.sv
// Multi-cycle EX operation tracker with watchdog.
// Ports: clk_i, rst_i (async high); mc_start_i, mc_done_i pulses;
//   hold_i freezes state/count; busy_o = in MC_BUSY; stall_o = EX held;
//   flush_o = bubble into EX/MEM; timeout_o = sticky watchdog flag.
module hazard_mc_fsm
    import hazard_pkg::*;
#(
    parameter int MC_TIMEOUT = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic mc_start_i,
    input  logic mc_done_i,
    input  logic hold_i,
    output logic busy_o,
    output logic stall_o,
    output logic flush_o,
    output logic timeout_o
);

    localparam int CNT_W = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MC_TIMEOUT - 1);

    hz_state_e        state_q, state_d;
    logic [CNT_W-1:0] mc_cnt_q, mc_cnt_d;
    logic             timeout_q, timeout_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= RUN;
            mc_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mc_cnt_q  <= mc_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mc_cnt_d  = mc_cnt_q;
        timeout_d = timeout_q;
        stall_o   = 1'b0;
        flush_o   = 1'b0;
        unique case (state_q)
            RUN: begin
                // Start and done together means the op finished in one cycle.
                stall_o = mc_start_i && !mc_done_i;
                if (!hold_i && stall_o) begin
                    state_d  = MC_BUSY;
                    mc_cnt_d = '0;
                end
            end
            MC_BUSY: begin
                stall_o = !mc_done_i;
                flush_o = !mc_done_i;
                if (!hold_i) begin
                    if (mc_done_i) begin
                        state_d = RUN;
                    end else if (mc_cnt_q == CNT_LAST) begin
                        timeout_d = 1'b1;
                        state_d   = RUN;
                        mc_cnt_d  = '0;
                    end else begin
                        mc_cnt_d = mc_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    assign busy_o    = (state_q == MC_BUSY);
    assign timeout_o = timeout_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch kill, MUL/DIV stall,
// data-memory wait freeze. Optional perf counters under HAZARD_PERF_EN.
// Inputs: ID sources/uses, EX load/rd/pc-select/mc_start, mc_done, dmem_wait.
// Outputs: pipeline register enables and flushes, mc_timeout, perf counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int LOAD_LAT   = 1,
    parameter int MC_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] rs1_id,
    input  logic [REG_ADDR_W-1:0] rs2_id,
    input  logic                  rs1_used_id,
    input  logic                  rs2_used_id,
    input  logic                  mem_read_ex,
    input  logic [REG_ADDR_W-1:0] rd_ex,
    input  logic [1:0]            if_mux_sel_ex,
    input  logic                  mc_start_ex,
    input  logic                  mc_done,
    input  logic                  dmem_wait,
    output logic                  pc_en,
    output logic                  if_id_en,
    output logic                  id_ex_en,
    output logic                  ex_mem_en,
    output logic                  mem_wb_en,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  ex_mem_flush,
    output logic                  mc_timeout,
    output logic [31:0]           perf_stall_cnt,
    output logic [31:0]           perf_flush_cnt
);

    logic       match;
    logic       redirect;
    logic       lu_stall;
    logic       lu_hold;
    logic       mc_busy;
    logic       mc_stall;
    logic       mc_flush;
    logic [1:0] ld_cnt_q, ld_cnt_d;

    assign match = mem_read_ex && (rd_ex != '0) &&
                   ((rs1_used_id && (rd_ex == rs1_id)) ||
                    (rs2_used_id && (rd_ex == rs2_id)));

    assign redirect = is_redirect(if_mux_sel_ex);
    assign lu_stall = (!mc_busy && match) || (ld_cnt_q != 2'd0);
    // A redirect fetches the target, so it cancels the front-end hold.
    assign lu_hold  = lu_stall && !redirect;

    always_comb begin
        ld_cnt_d = ld_cnt_q;
        if (!dmem_wait) begin
            if (redirect) begin
                ld_cnt_d = 2'd0;
            end else if (!mc_busy && match) begin
                ld_cnt_d = 2'(LOAD_LAT - 1);
            end else if (ld_cnt_q != 2'd0) begin
                ld_cnt_d = ld_cnt_q - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_cnt_q <= 2'd0;
        end else begin
            ld_cnt_q <= ld_cnt_d;
        end
    end

    hazard_mc_fsm #(
        .MC_TIMEOUT(MC_TIMEOUT)
    ) u_mc_fsm (
        .clk_i     (clk),
        .rst_i     (rst),
        .mc_start_i(mc_start_ex),
        .mc_done_i (mc_done),
        .hold_i    (dmem_wait),
        .busy_o    (mc_busy),
        .stall_o   (mc_stall),
        .flush_o   (mc_flush),
        .timeout_o (mc_timeout)
    );

    // dmem_wait freezes every stage and suppresses all bubbles.
    always_comb begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_en    = 1'b0;
        mem_wb_en    = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        if (!dmem_wait) begin
            pc_en        = !(lu_hold || mc_stall);
            if_id_en     = !(lu_hold || mc_stall);
            id_ex_en     = !mc_stall;
            ex_mem_en    = 1'b1;
            mem_wb_en    = 1'b1;
            if_id_flush  = redirect;
            id_ex_flush  = redirect || lu_stall;
            ex_mem_flush = mc_flush;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!pc_en) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (if_id_flush) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomised + directed bench for hazard_ctrl, three parameter sets
// (LOAD_LAT 1/2/3, MC_TIMEOUT 8/64/8) driven from shared stimulus.
module tb_hazard_ctrl;

    localparam int N = 3;

    logic       clk;
    logic       rst;
    logic [4:0] rs1_id, rs2_id, rd_ex;
    logic       rs1_used_id, rs2_used_id, mem_read_ex;
    logic [1:0] if_mux_sel_ex;
    logic       mc_start_ex, mc_done, dmem_wait;

    // {pc,if_id,id_ex,ex_mem,mem_wb enables, if_id,id_ex,ex_mem flushes, timeout}
    logic [8:0]  ctl [N];
    logic [31:0] pst [N];
    logic [31:0] pfl [N];

    int n_assert = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int TO_G = (g == 1) ? 64 : 8;
        logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
        logic if_id_flush, id_ex_flush, ex_mem_flush, mc_timeout;
        logic [31:0] s_cnt, f_cnt;

        hazard_ctrl #(
            .REG_ADDR_W(5),
            .LOAD_LAT  (g + 1),
            .MC_TIMEOUT(TO_G)
        ) u_dut (
            .clk           (clk),
            .rst           (rst),
            .rs1_id        (rs1_id),
            .rs2_id        (rs2_id),
            .rs1_used_id   (rs1_used_id),
            .rs2_used_id   (rs2_used_id),
            .mem_read_ex   (mem_read_ex),
            .rd_ex         (rd_ex),
            .if_mux_sel_ex (if_mux_sel_ex),
            .mc_start_ex   (mc_start_ex),
            .mc_done       (mc_done),
            .dmem_wait     (dmem_wait),
            .pc_en         (pc_en),
            .if_id_en      (if_id_en),
            .id_ex_en      (id_ex_en),
            .ex_mem_en     (ex_mem_en),
            .mem_wb_en     (mem_wb_en),
            .if_id_flush   (if_id_flush),
            .id_ex_flush   (id_ex_flush),
            .ex_mem_flush  (ex_mem_flush),
            .mc_timeout    (mc_timeout),
            .perf_stall_cnt(s_cnt),
            .perf_flush_cnt(f_cnt)
        );

        assign ctl[g] = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                         if_id_flush, id_ex_flush, ex_mem_flush, mc_timeout};
        assign pst[g] = s_cnt;
        assign pfl[g] = f_cnt;
    end

    // Reference model: plain counters per instance.
    int          m_busy [N];
    int          m_cnt  [N];
    int          m_bub  [N];
    int          m_to   [N];
    logic [31:0] m_pst  [N];
    logic [31:0] m_pfl  [N];

    // Observation stats over a directed window (from DUT values).
    int         low_n [N];
    int         emf_n [N];
    int         idf_n [N];
    logic [8:0] last  [N];

    function automatic int ll_of(int i);
        return i + 1;
    endfunction

    function automatic int to_of(int i);
        return (i == 1) ? 64 : 8;
    endfunction

    function automatic bit is_match();
        return mem_read_ex && rd_ex != 0 &&
               ((rs1_used_id && rd_ex == rs1_id) ||
                (rs2_used_id && rd_ex == rs2_id));
    endfunction

    function automatic bit is_br();
        return if_mux_sel_ex == 2'd1 || if_mux_sel_ex == 2'd2;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_busy[i] = 0;
            m_cnt[i]  = 0;
            m_bub[i]  = 0;
            m_to[i]   = 0;
            m_pst[i]  = '0;
            m_pfl[i]  = '0;
        end
    endtask

    function automatic logic [8:0] model_ctl(int i);
        logic [8:0] r;
        bit lu, mcs, pc;
        r    = '0;
        r[0] = (m_to[i] != 0);
        if (dmem_wait) return r;
        lu   = (m_busy[i] == 0 && is_match()) || m_bub[i] > 0;
        mcs  = (m_busy[i] != 0) ? !mc_done : (mc_start_ex && !mc_done);
        pc   = !mcs && !(lu && !is_br());
        r[8] = pc;
        r[7] = pc;
        r[6] = !mcs;
        r[5] = 1'b1;
        r[4] = 1'b1;
        r[3] = is_br();
        r[2] = is_br() || lu;
        r[1] = (m_busy[i] != 0) && !mc_done;
        return r;
    endfunction

    task automatic advance(int i, logic [8:0] e);
        if (e[8] == 1'b0) m_pst[i] = m_pst[i] + 32'd1;
        if (e[3] == 1'b1) m_pfl[i] = m_pfl[i] + 32'd1;
        if (dmem_wait) return;
        if (is_br())                             m_bub[i] = 0;
        else if (m_busy[i] == 0 && is_match())   m_bub[i] = ll_of(i) - 1;
        else if (m_bub[i] > 0)                   m_bub[i] = m_bub[i] - 1;
        if (m_busy[i] == 0) begin
            if (mc_start_ex && !mc_done) begin
                m_busy[i] = 1;
                m_cnt[i]  = 0;
            end
        end else if (mc_done) begin
            m_busy[i] = 0;
        end else if (m_cnt[i] == to_of(i) - 1) begin
            m_to[i]   = 1;
            m_busy[i] = 0;
        end else begin
            m_cnt[i] = m_cnt[i] + 1;
        end
    endtask

    task automatic check(string nm, int inst, logic [31:0] act,
                         logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d: got 0x%0h expected 0x%0h",
                     nm, inst, act, exp);
        end
    endtask

    task automatic clr_stats();
        for (int i = 0; i < N; i++) begin
            low_n[i] = 0;
            emf_n[i] = 0;
            idf_n[i] = 0;
        end
    endtask

    // One clock: compare at negedge, advance model, return at posedge+1.
    task automatic tick();
        logic [8:0] e;
        @(negedge clk);
        if (rst) model_reset();
        for (int i = 0; i < N; i++) begin
            e = model_ctl(i);
            check("ctl", i, 32'(ctl[i]), 32'(e));
`ifdef HAZARD_PERF_EN
            check("perf_stall", i, pst[i], m_pst[i]);
            check("perf_flush", i, pfl[i], m_pfl[i]);
`else
            check("perf_stall_tied", i, pst[i], 32'd0);
            check("perf_flush_tied", i, pfl[i], 32'd0);
`endif
            last[i] = ctl[i];
            if (!ctl[i][8]) low_n[i]++;
            if (ctl[i][1])  emf_n[i]++;
            if (ctl[i][2])  idf_n[i]++;
            if (!rst) advance(i, e);
        end
        if (rst) model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rs1_id        = 5'd1;
        rs2_id        = 5'd2;
        rd_ex         = 5'd0;
        rs1_used_id   = 1'b0;
        rs2_used_id   = 1'b0;
        mem_read_ex   = 1'b0;
        if_mux_sel_ex = 2'd0;
        mc_start_ex   = 1'b0;
        mc_done       = 1'b0;
        dmem_wait     = 1'b0;
    endtask

    task automatic ticks(int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic load_use(logic [4:0] rd, logic [4:0] r1, logic u1,
                            logic [4:0] r2, logic u2);
        mem_read_ex = 1'b1;
        rd_ex       = rd;
        rs1_id      = r1;
        rs1_used_id = u1;
        rs2_id      = r2;
        rs2_used_id = u2;
    endtask

    task automatic async_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
        #1;
    endtask

    logic [31:0] f0;

    initial begin
        idle();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        for (int i = 0; i < N; i++) check("reset_idle", i, 32'(ctl[i]), 32'h1F0);

        // Load-use: bubbles equal LOAD_LAT.
        clr_stats();
        load_use(5'd5, 5'd5, 1'b1, 5'd1, 1'b1);
        tick();
        idle();
        ticks(4);
        for (int i = 0; i < N; i++) begin
            check("lu_bubbles", i, low_n[i], ll_of(i));
            check("lu_idex_flush", i, idf_n[i], ll_of(i));
        end

        // rd_ex == x0 never stalls.
        clr_stats();
        load_use(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
        tick();
        idle();
        ticks(3);
        for (int i = 0; i < N; i++) check("lu_x0", i, low_n[i], 0);

        // rs2 matches but is unused.
        clr_stats();
        load_use(5'd7, 5'd3, 1'b1, 5'd7, 1'b0);
        tick();
        idle();
        ticks(3);
        for (int i = 0; i < N; i++) check("lu_rs2_unused", i, low_n[i], 0);

        // Branch redirect during a load-use stall.
        clr_stats();
        f0 = pfl[2];
        load_use(5'd5, 5'd5, 1'b1, 5'd1, 1'b0);
        tick();
        idle();
        if_mux_sel_ex = 2'd1;
        tick();
        check("br_over_lu", 2, 32'(last[2]), 32'h1FC);
        idle();
        ticks(3);
        for (int i = 0; i < N; i++) check("br_lu_stalls", i, low_n[i], 1);
`ifdef HAZARD_PERF_EN
        check("br_perf_flush", 2, pfl[2] - f0, 32'd1);
`endif

        // Multi-cycle op: start t0, done t0+5.
        clr_stats();
        mc_start_ex = 1'b1;
        tick();
        check("mc_start_cycle", 0, 32'(last[0]), 32'h030);
        idle();
        ticks(4);
        mc_done = 1'b1;
        tick();
        idle();
        tick();
        for (int i = 0; i < N; i++) begin
            check("mc_stall_cycles", i, low_n[i], 5);
            check("mc_exmem_flush", i, emf_n[i], 4);
            check("mc_back_run", i, 32'(last[i]), 32'h1F0);
        end

        // Start and done together: no stall.
        clr_stats();
        mc_start_ex = 1'b1;
        mc_done     = 1'b1;
        tick();
        idle();
        tick();
        for (int i = 0; i < N; i++) check("mc_same_cycle", i, low_n[i], 0);

        // Watchdog with MC_TIMEOUT=8 on instances 0 and 2.
        clr_stats();
        mc_start_ex = 1'b1;
        tick();
        idle();
        ticks(11);
        check("wd_stalls", 0, low_n[0], 9);
        check("wd_stalls", 2, low_n[2], 9);
        check("wd_busy64", 1, low_n[1], 12);
        check("wd_flag", 0, 32'(last[0][0]), 32'd1);
        mc_done = 1'b1;
        tick();
        idle();
        ticks(5);
        check("wd_sticky", 0, 32'(last[0]), 32'h1F1);
        check("wd_sticky", 2, 32'(last[2]), 32'h1F1);
        check("wd_none", 1, 32'(last[1]), 32'h1F0);

        // dmem_wait mid MC_BUSY freezes the watchdog counter.
        clr_stats();
        mc_start_ex = 1'b1;
        tick();
        idle();
        ticks(2);
        dmem_wait = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            for (int i = 0; i < N; i++)
                check("dmem_freeze", i, 32'(last[i][8:1]), 32'd0);
        end
        dmem_wait = 1'b0;
        ticks(7);
        check("dmem_wd_frozen", 0, low_n[0], 12);
        check("dmem_wd_frozen", 2, low_n[2], 12);
        check("dmem_busy64", 1, low_n[1], 13);

        // Async reset while instance 1 is still busy.
        async_reset();
        for (int i = 0; i < N; i++) begin
            check("rst_abort", i, 32'(ctl[i]), 32'h1F0);
`ifdef HAZARD_PERF_EN
            check("rst_perf_s", i, pst[i], 32'd0);
            check("rst_perf_f", i, pfl[i], 32'd0);
`endif
        end
        tick();

        // Randomised traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            rs1_id        = 5'($urandom_range(0, 7));
            rs2_id        = 5'($urandom_range(0, 7));
            rd_ex         = 5'($urandom_range(0, 7));
            rs1_used_id   = 1'($urandom_range(0, 1));
            rs2_used_id   = 1'($urandom_range(0, 1));
            mem_read_ex   = ($urandom_range(0, 9) < 3);
            if_mux_sel_ex = ($urandom_range(0, 9) < 2) ?
                            2'($urandom_range(1, 3)) : 2'd0;
            mc_start_ex   = ($urandom_range(0, 9) == 0);
            mc_done       = ($urandom_range(0, 9) == 0);
            dmem_wait     = ($urandom_range(0, 9) == 0);
            rst           = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;
        idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
